// File: rtl/bus_arbiter_if.sv
// MPU/DMA/memory bus bundle for bus_arbiter; slave modport is the arbiter's view.
// Master modport drives MPU and DMA requests and observes the arbitrated memory bus.
interface bus_arbiter_if #(
    parameter int CNT_WIDTH = 16
);
    logic [15:0]          MPU_AB;
    logic                 MPU_R_W;
    logic [7:0]           MPU_DB_OUT;
    logic                 RDY;
    logic                 DMA_REQ;
    logic [15:0]          DMA_AB;
    logic                 DMA_R_W;
    logic [7:0]           DMA_WD;
    logic                 DMA_GNT;
    logic [15:0]          A;
    logic                 WE;
    logic [7:0]           WD;
    logic                 BUSY;
    logic [CNT_WIDTH-1:0] STEAL_CNT;

    modport slave (
        input  MPU_AB, MPU_R_W, MPU_DB_OUT, DMA_REQ, DMA_AB, DMA_R_W, DMA_WD,
        output RDY, DMA_GNT, A, WE, WD, BUSY, STEAL_CNT
    );

    modport master (
        output MPU_AB, MPU_R_W, MPU_DB_OUT, DMA_REQ, DMA_AB, DMA_R_W, DMA_WD,
        input  RDY, DMA_GNT, A, WE, WD, BUSY, STEAL_CNT
    );
endinterface

// File: rtl/bus_arbiter.sv
// Cycle-stealing DMA arbiter: grants MPU read cycles to DMA; BUS_ARBITER_FAIRNESS_EN adds a forced MPU cycle after MAX_BURST steals.
// Grant and bus mux are combinational (zero latency); MPU is stalled via RDY=0 only during reads.
module bus_arbiter #(
    parameter int MAX_BURST = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic          CLK,
    input  logic          RES_N,
    bus_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        COOL  = 2'd2
    } state_t;

    if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_max_burst
        $error("bus_arbiter: MAX_BURST out of range 1..255");
    end

    state_t               r_state;
    state_t               w_state_nxt;
    logic [7:0]           r_burst_cnt;
    logic [7:0]           w_burst_nxt;
    logic [CNT_WIDTH-1:0] r_steal_cnt;
    logic [CNT_WIDTH-1:0] w_steal_nxt;
    logic                 w_grant;

    // RES_N is in the grant term so reset drops the bus asynchronously, mid-cycle.
    assign w_grant = bus.DMA_REQ & bus.MPU_R_W & RES_N & (r_state != COOL);

    assign bus.RDY       = ~w_grant;
    assign bus.DMA_GNT   = w_grant;
    assign bus.A         = w_grant ? bus.DMA_AB : bus.MPU_AB;
    assign bus.WD        = w_grant ? bus.DMA_WD : bus.MPU_DB_OUT;
    assign bus.WE        = RES_N & (w_grant ? ~bus.DMA_R_W : ~bus.MPU_R_W);
    assign bus.BUSY      = (r_state == BURST);
    assign bus.STEAL_CNT = r_steal_cnt;

    always_comb begin
        w_state_nxt = IDLE;
        w_burst_nxt = 8'd0;
        w_steal_nxt = r_steal_cnt;
        if (w_grant) begin
            if (r_steal_cnt != {CNT_WIDTH{1'b1}}) begin
                w_steal_nxt = r_steal_cnt + 1'b1;
            end
`ifdef BUS_ARBITER_FAIRNESS_EN
            // Counter never exceeds MAX_BURST-1 here, so the increment cannot wrap.
            if ((r_burst_cnt + 8'd1) == 8'(MAX_BURST)) begin
                w_state_nxt = COOL;
                w_burst_nxt = 8'd0;
            end else begin
                w_state_nxt = BURST;
                w_burst_nxt = r_burst_cnt + 8'd1;
            end
`else
            w_state_nxt = BURST;
            w_burst_nxt = (r_burst_cnt == 8'hFF) ? 8'hFF : r_burst_cnt + 8'd1;
`endif
        end
    end

    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            r_state     <= IDLE;
            r_burst_cnt <= 8'd0;
            r_steal_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_burst_cnt <= w_burst_nxt;
            r_steal_cnt <= w_steal_nxt;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: vector table for the MPU/DMA cycle mix plus hand sequences for bursts, reset and saturation.
module tb_bus_arbiter;

    logic CLK;
    logic RES_N;

    bus_arbiter_if #(.CNT_WIDTH(16)) bus ();
    bus_arbiter_if #(.CNT_WIDTH(4))  bus2 ();

    bus_arbiter #(.MAX_BURST(4), .CNT_WIDTH(16)) dut (
        .CLK   (CLK),
        .RES_N (RES_N),
        .bus   (bus)
    );

    bus_arbiter #(.MAX_BURST(8), .CNT_WIDTH(4)) dut2 (
        .CLK   (CLK),
        .RES_N (RES_N),
        .bus   (bus2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic [7:0] mem [0:4095] = '{default: 8'h00};
    always @(posedge CLK) begin
        if (bus.WE) mem[bus.A[11:0]] <= bus.WD;
    end

    typedef struct {
        logic [15:0] mab;
        logic        mrw;
        logic [7:0]  mdb;
        logic        req;
        logic [15:0] dab;
        logic        drw;
        logic [7:0]  dwd;
        logic        rdy;
        logic        gnt;
        logic [15:0] a;
        logic        we;
        logic [7:0]  wd;
        logic        busy;
        logic [15:0] sc;
    } vec_t;

    vec_t vecs [10];
    int   n_vec;
    int   n_bad;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [15:0] mab, input logic mrw, input logic [7:0] mdb,
                         input logic req, input logic [15:0] dab, input logic drw,
                         input logic [7:0] dwd);
        bus.MPU_AB     = mab;
        bus.MPU_R_W    = mrw;
        bus.MPU_DB_OUT = mdb;
        bus.DMA_REQ    = req;
        bus.DMA_AB     = dab;
        bus.DMA_R_W    = drw;
        bus.DMA_WD     = dwd;
    endtask

    function automatic logic [63:0] pack_out(input logic rdy, input logic gnt, input logic [15:0] a,
                                             input logic we, input logic [7:0] wd, input logic busy,
                                             input logic [15:0] sc);
        return {20'd0, rdy, gnt, a, we, wd, busy, sc};
    endfunction

    initial begin
        int exp_sc;
        logic exp_g;
        logic exp_b;
        n_vec = 0;
        n_bad = 0;

        //        mab    mrw  mdb    req  dab    drw  dwd    rdy  gnt  a      we   wd     busy sc
        vecs[0] = '{16'h0000, 1'b1, 8'h00, 1'b0, 16'h0000, 1'b1, 8'h00, 1'b1, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 16'd0};
        vecs[1] = '{16'h0001, 1'b1, 8'h00, 1'b0, 16'h0000, 1'b1, 8'h00, 1'b1, 1'b0, 16'h0001, 1'b0, 8'h00, 1'b0, 16'd0};
        vecs[2] = '{16'h0200, 1'b0, 8'h42, 1'b1, 16'h0300, 1'b0, 8'hA1, 1'b1, 1'b0, 16'h0200, 1'b1, 8'h42, 1'b0, 16'd0};
        vecs[3] = '{16'h0005, 1'b1, 8'h00, 1'b1, 16'h0300, 1'b0, 8'hA1, 1'b0, 1'b1, 16'h0300, 1'b1, 8'hA1, 1'b0, 16'd0};
        vecs[4] = '{16'h0005, 1'b1, 8'h00, 1'b1, 16'h0301, 1'b0, 8'hA2, 1'b0, 1'b1, 16'h0301, 1'b1, 8'hA2, 1'b1, 16'd1};
        vecs[5] = '{16'h0005, 1'b1, 8'h00, 1'b1, 16'h0302, 1'b0, 8'hA3, 1'b0, 1'b1, 16'h0302, 1'b1, 8'hA3, 1'b1, 16'd2};
        vecs[6] = '{16'h0005, 1'b1, 8'h00, 1'b0, 16'h0302, 1'b0, 8'hA3, 1'b1, 1'b0, 16'h0005, 1'b0, 8'h00, 1'b1, 16'd3};
        vecs[7] = '{16'h0006, 1'b1, 8'h00, 1'b1, 16'h0400, 1'b1, 8'h55, 1'b0, 1'b1, 16'h0400, 1'b0, 8'h55, 1'b0, 16'd3};
        vecs[8] = '{16'h0201, 1'b0, 8'h77, 1'b1, 16'h0400, 1'b1, 8'h55, 1'b1, 1'b0, 16'h0201, 1'b1, 8'h77, 1'b1, 16'd4};
        vecs[9] = '{16'h0007, 1'b1, 8'h00, 1'b0, 16'h0400, 1'b1, 8'h55, 1'b1, 1'b0, 16'h0007, 1'b0, 8'h00, 1'b0, 16'd4};

        // Reset held with a DMA write request pending during an MPU read.
        RES_N = 1'b0;
        drive(16'h1234, 1'b1, 8'h5A, 1'b1, 16'h0300, 1'b0, 8'hEE);
        bus2.MPU_AB = 16'h0000; bus2.MPU_R_W = 1'b1; bus2.MPU_DB_OUT = 8'h00;
        bus2.DMA_REQ = 1'b0; bus2.DMA_AB = 16'h0000; bus2.DMA_R_W = 1'b1; bus2.DMA_WD = 8'h00;
        repeat (2) @(negedge CLK);
        #2;
        chk("reset_outputs", pack_out(bus.RDY, bus.DMA_GNT, bus.A, bus.WE, bus.WD, bus.BUSY, bus.STEAL_CNT),
            pack_out(1'b1, 1'b0, 16'h1234, 1'b0, 8'h5A, 1'b0, 16'd0));
        chk("reset_steal2", {60'd0, bus2.STEAL_CNT}, 64'd0);

        @(negedge CLK);
        RES_N = 1'b1;

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].mab, vecs[i].mrw, vecs[i].mdb, vecs[i].req,
                  vecs[i].dab, vecs[i].drw, vecs[i].dwd);
            #2;
            chk($sformatf("vec%0d", i),
                pack_out(bus.RDY, bus.DMA_GNT, bus.A, bus.WE, bus.WD, bus.BUSY, bus.STEAL_CNT),
                pack_out(vecs[i].rdy, vecs[i].gnt, vecs[i].a, vecs[i].we, vecs[i].wd, vecs[i].busy, vecs[i].sc));
            @(negedge CLK);
        end

        chk("mem_0200", {56'd0, mem[12'h200]}, 64'h42);
        chk("mem_0300", {56'd0, mem[12'h300]}, 64'hA1);
        chk("mem_0301", {56'd0, mem[12'h301]}, 64'hA2);
        chk("mem_0302", {56'd0, mem[12'h302]}, 64'hA3);
        chk("mem_0201", {56'd0, mem[12'h201]}, 64'h77);
        chk("mem_0400", {56'd0, mem[12'h400]}, 64'h00);

        // DMA_REQ held high through MPU reads: long burst grant pattern.
        for (int i = 0; i < 10; i++) begin
            drive(16'h0008, 1'b1, 8'h00, 1'b1, 16'h0600, 1'b1, 8'h00);
            #2;
`ifdef BUS_ARBITER_FAIRNESS_EN
            exp_g = ((i % 5) != 4);
            exp_b = ((i % 5) >= 1) && ((i % 5) <= 3);
`else
            exp_g = 1'b1;
            exp_b = (i != 0);
`endif
            chk($sformatf("burst%0d", i), {61'd0, bus.DMA_GNT, bus.RDY, bus.BUSY},
                {61'd0, exp_g, ~exp_g, exp_b});
            @(negedge CLK);
        end

        drive(16'h0009, 1'b1, 8'h00, 1'b0, 16'h0000, 1'b1, 8'h00);
        @(negedge CLK);

        // Reset mid-burst while a DMA write is on the bus.
        drive(16'h0010, 1'b1, 8'h00, 1'b1, 16'h0500, 1'b0, 8'hEE);
        #2;
        chk("mid_gnt0", {63'd0, bus.DMA_GNT}, 64'd1);
        @(negedge CLK);
        drive(16'h0010, 1'b1, 8'h00, 1'b1, 16'h0501, 1'b0, 8'hEF);
        #2;
        chk("mid_gnt1", {62'd0, bus.DMA_GNT, bus.BUSY}, 64'd3);
        @(negedge CLK);
        drive(16'h0010, 1'b1, 8'h00, 1'b1, 16'h0502, 1'b0, 8'hF0);
        #1;
        chk("mid_gnt2", {63'd0, bus.DMA_GNT}, 64'd1);
        RES_N = 1'b0;
        #1;
        chk("mid_reset", pack_out(bus.RDY, bus.DMA_GNT, bus.A, bus.WE, bus.WD, bus.BUSY, bus.STEAL_CNT),
            pack_out(1'b1, 1'b0, 16'h0010, 1'b0, 8'h00, 1'b0, 16'd0));
        @(posedge CLK);
        #1;
        chk("mid_nowrite", {56'd0, mem[12'h502]}, 64'h00);
        chk("mid_prior_write", {56'd0, mem[12'h500]}, 64'hEE);
        @(negedge CLK);
        RES_N = 1'b1;
        drive(16'h0011, 1'b1, 8'h00, 1'b0, 16'h0000, 1'b1, 8'h00);
        #2;
        chk("post_reset", {47'd0, bus.BUSY, bus.STEAL_CNT}, 64'd0);
        @(negedge CLK);

        // 4-bit counter saturation on the second instance.
        exp_sc = 0;
        bus2.DMA_REQ = 1'b1;
        bus2.MPU_R_W = 1'b1;
        bus2.DMA_R_W = 1'b1;
        for (int k = 0; k < 25; k++) begin
            #2;
            chk($sformatf("sat%0d", k), {60'd0, bus2.STEAL_CNT}, 64'(exp_sc));
`ifdef BUS_ARBITER_FAIRNESS_EN
            exp_g = ((k % 9) != 8);
`else
            exp_g = 1'b1;
`endif
            if (exp_g && exp_sc != 15) exp_sc++;
            @(negedge CLK);
        end
        #2;
        chk("sat_final", {60'd0, bus2.STEAL_CNT}, 64'd15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
